// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_CH-input valid/ready arbiter with one registered output beat.
// Channels are chosen either by round-robin rotation after the last granted
// channel or by an explicit force_sel. A single output buffer gives one beat
// per cycle when the sink is always ready (pop and refill in the same cycle).
// Optional burst lock: define RR_ARB_MUX_LOCK_EN to add the in_lock port.
module rr_arb_mux #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
   input  logic [NUM_CH-1:0]       in_lock,
`endif
   input  logic                    force_en,
   input  logic [SEL_W-1:0]        force_sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_ch
);

   // Pointer starts at the highest channel so channel 0 wins the first search.
   localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_CH - 1);

   logic [SEL_W-1:0] last_q;
   logic             free_p0;
   logic             grant_vld_p0;
   logic [SEL_W-1:0] grant_p0;
   logic [WIDTH-1:0] grant_data_p0;
   logic             xfer_p0;
`ifdef RR_ARB_MUX_LOCK_EN
   logic             lock_act_q;
   logic [SEL_W-1:0] lock_ch_q;
   logic             grant_lock_p0;
`endif

   // ---- stage p0: grant evaluation (combinational) ----
   // Buffer can accept a new beat; held low during reset so no ready leaks out.
   assign free_p0 = rst_n & (~out_valid | out_ready);
   assign xfer_p0 = free_p0 & grant_vld_p0;

   // Select the winning channel: forced, locked, or round-robin after last_q.
   always_comb begin : grant_sel
      int idx;
      idx          = 0;
      grant_vld_p0 = 1'b0;
      grant_p0     = '0;
      if (force_en) begin
         // Out-of-range force_sel never matches a k, so it yields no grant.
         for (int k = 0; k < NUM_CH; k++) begin
            if (int'(force_sel) == k && in_valid[k]) begin
               grant_vld_p0 = 1'b1;
               grant_p0     = SEL_W'(k);
            end
         end
      end
`ifdef RR_ARB_MUX_LOCK_EN
      else if (lock_act_q) begin
         // Locked: only the owning channel may be granted, others wait.
         for (int k = 0; k < NUM_CH; k++) begin
            if (int'(lock_ch_q) == k && in_valid[k]) begin
               grant_vld_p0 = 1'b1;
               grant_p0     = SEL_W'(k);
            end
         end
      end
`endif
      else begin
         // Search last+1 .. last (inclusive), wrapping modulo NUM_CH.
         for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            for (int k = 0; k < NUM_CH; k++) begin
               if (!grant_vld_p0 && k == idx && in_valid[k]) begin
                  grant_vld_p0 = 1'b1;
                  grant_p0     = SEL_W'(k);
               end
            end
         end
      end
   end

   // Route the granted channel's data and produce the one-hot ready vector.
   always_comb begin
      grant_data_p0 = '0;
      in_ready      = '0;
`ifdef RR_ARB_MUX_LOCK_EN
      grant_lock_p0 = 1'b0;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
         if (int'(grant_p0) == k) begin
            grant_data_p0 = in_data[k*WIDTH +: WIDTH];
            in_ready[k]   = free_p0 & grant_vld_p0;
`ifdef RR_ARB_MUX_LOCK_EN
            grant_lock_p0 = in_lock[k];
`endif
         end
      end
   end

   // ---- stage p1: output buffer (registered) ----
   // Load on transfer, drop valid on a pop with no refill; data/ch hold stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (xfer_p0) begin
         out_valid <= 1'b1;
         out_data  <= grant_data_p0;
         out_ch    <= grant_p0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer advances only on transfers made in round-robin mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= LAST_RST;
      end else if (xfer_p0 && !force_en) begin
         last_q <= grant_p0;
      end
   end

`ifdef RR_ARB_MUX_LOCK_EN
   // Lock is taken or released by round-robin transfers; forced traffic leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_act_q <= 1'b0;
         lock_ch_q  <= '0;
      end else if (xfer_p0 && !force_en) begin
         lock_act_q <= grant_lock_p0;
         lock_ch_q  <= grant_p0;
      end
   end
`endif

endmodule
